mips_datapath_param: RTL and testbench
======================================

# mips_datapath_param

Parametrised multicycle MIPS datapath, the successor to the fixed 8-bit datapath. Register file size and data width are parameters. An internal fetch sequencer replaces the one-hot `irwrite` byte strobes: it assembles the 32-bit instruction from `32/WIDTH` memory beats under a valid handshake. The block sits between the multicycle controller (control inputs, `op`/`funct`/`zero`/fetch status back) and the unified instruction/data memory (`addr`, `wdata`, `memdata`).

## Interface
- `WIDTH`, 8: datapath/memory word width; legal values 8, 16, 32. `BEATS = 32/WIDTH`, `SH = log2(BEATS)`.
- `REGBITS`, 3: register file has `2**REGBITS` entries of `WIDTH` bits; entry 0 reads zero.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `fetch_start`  in  1  request instruction fetch at current PC.
- `mem_valid`  in  1  `memdata` holds a valid fetch beat this cycle.
- `memdata`  in  WIDTH  memory read data.
- `pcen`  in  1  PC write enable.
- `iord`  in  1  0: addr=PC, 1: addr=ALUOut (outside fetch).
- `regdst`  in  1  write address 0: rt, 1: rd.
- `memtoreg`  in  1  write-back 0: ALUOut, 1: MDR.
- `regwrite`  in  1  register file write enable.
- `alusrca`  in  1  0: PC, 1: A.
- `alusrcb`  in  2  00: B, 01: BEATS, 10: immx, 11: immx<<SH.
- `alucont`  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt; others give 0.
- `pcsource`  in  2  00: ALU result, 01: ALUOut, 10: jump target, 11: hold.
- `op`  out  6  IR[31:26].
- `funct`  out  6  IR[5:0].
- `zero`  out  1  ALU result == 0 (combinational).
- `addr`  out  WIDTH  memory address.
- `wdata`  out  WIDTH  store data (B register).
- `fetch_busy`  out  1  sequencer in FETCH.
- `fetch_done`  out  1  one-cycle pulse, instruction complete.

## Operation
- Reset (async, immediate): PC, IR, MDR, A, B, ALUOut, all registers, beat counter = 0; state IDLE; `fetch_busy`=`fetch_done`=0; `op`=`funct`=`addr`=`wdata`=0.
- Fetch FSM, states IDLE and FETCH:
  - IDLE + `fetch_start` → FETCH, beat=0. `mem_valid` in IDLE is ignored.
  - In FETCH, each cycle with `mem_valid`: `IR[beat*WIDTH +: WIDTH] <= memdata` (beat 0 = LSBs), then beat+1.
  - The final beat returns the FSM to IDLE and drives `fetch_done`=1 for the next cycle.
  - `mem_valid` low stalls the fetch with no state change.
  - `fetch_start` while in FETCH is ignored.
- `addr`: `PC + beat` (mod 2^WIDTH) while `fetch_busy`; otherwise `iord ? ALUOut : PC`.
- `pcen` is ignored while `fetch_busy`.
- Per-cycle registers, updated every edge: MDR←`memdata`, A←rf[rs], B←rf[rt], ALUOut←ALU result.
- Register file indices:
  - rs = IR[21 +: REGBITS], rt = IR[16 +: REGBITS], rd = IR[11 +: REGBITS].
  - Reads are combinational. A write on edge N is visible from cycle N+1; a same-cycle read of the written entry returns the old value.
  - Writes to entry 0 are discarded.
- immx: IR[15:0] sign-extended to WIDTH when WIDTH=32; IR[WIDTH-1:0] otherwise.
- Jump target: `IR[25:0] << SH`, truncated to WIDTH.
- ALU: all arithmetic modulo 2^WIDTH. slt is signed, result 1 or 0.

## Timing
- Fetch latency: BEATS cycles after the accept edge with `mem_valid` continuously high; `fetch_done` follows on the next cycle. Each stalled cycle adds one.
- `op` and `funct` change on the edge that writes their beat.
- `zero`, `addr` and `fetch_busy` are combinational from state. A, B, ALUOut and MDR carry one cycle of latency.

## Test plan
- WIDTH=8, PC=0: `fetch_start`, then beats 20,10,22,00 → IR=0x00221020, `funct`=0x20, `op`=0, `addr` steps 0,1,2,3, `fetch_done` high exactly one cycle after the 4th beat.
- WIDTH=8: `mem_valid` low for 2 cycles after beat 1 → `addr` holds 0x02, `fetch_busy` stays high for 6 cycles, IR still correct.
- WIDTH=8: load r1=0x05 and r2=0x05 via MDR (`memtoreg`=1). Sub with `alusrca`=1, `alusrcb`=00 → `zero`=1. With r1=0x80, r2=0x01, slt → result 1, `zero`=0.
- Write 0x7F to entry 0 with `regwrite`=1 → A/B read 0x00 next cycle.
- `reset` asserted mid-cycle after beat 2 → `fetch_busy`=0, IR=0, `addr`=0 before the next edge. The next fetch restarts at beat 0.
- WIDTH=32: single-beat fetch of 0x08000003, `pcsource`=10, `pcen`=1 → PC=0x00000003. `alusrcb`=01 with `pcsource`=00 → PC increments by 1.

Source files
------------

// File: rtl/mips_datapath_param.sv
// Parametrised multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, register file, ALU,
// and a beat sequencer that assembles each 32-bit instruction from 32/WIDTH memory beats.
module mips_datapath_param #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_start,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] memdata,
  input  logic             pcen,
  input  logic             iord,
  input  logic             regdst,
  input  logic             memtoreg,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [2:0]       alucont,
  input  logic [1:0]       pcsource,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] wdata,
  output logic             fetch_busy,
  output logic             fetch_done
);
  localparam int BEATS = 32 / WIDTH;
  localparam int SH    = $clog2(BEATS);
  localparam int NREGS = 2**REGBITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state, state_n;
  logic [1:0]         beat, beat_n;
  logic               ir_we, done_n;

  logic [31:0]        ir;
  logic [WIDTH-1:0]   pc, pc_n, mdr, a, b, aluout;
  logic [WIDTH-1:0]   rf [NREGS];
  logic [REGBITS-1:0] rs, rt, rd, wa;
  logic [WIDTH-1:0]   rd1, rd2, wd;
  logic [WIDTH-1:0]   immx, jtarget, srca, srcb, alu_res;

  // Fetch sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= 2'd0;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      fetch_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    ir_we   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_start) begin
          state_n = FETCH;
          beat_n  = 2'd0;
        end
      end
      FETCH: begin
        if (mem_valid) begin
          ir_we = 1'b1;
          if (int'(beat) == BEATS - 1) begin
            state_n = IDLE;
            beat_n  = 2'd0;
            done_n  = 1'b1;
          end else begin
            beat_n = beat + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign fetch_busy = (state == FETCH);

  // Beat 0 lands in the least significant slice of IR
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ir <= '0;
    else if (ir_we) ir[int'(beat)*WIDTH +: WIDTH] <= memdata;
  end

  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign rs    = ir[21 +: REGBITS];
  assign rt    = ir[16 +: REGBITS];
  assign rd    = ir[11 +: REGBITS];

  if (WIDTH == 32) begin : g_sext
    assign immx = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  end else begin : g_trunc
    assign immx = ir[WIDTH-1:0];
  end

  assign jtarget = WIDTH'({6'b0, ir[25:0]} << SH);

  // Register file: combinational read, entry 0 hard-wired to zero
  assign wa  = regdst ? rd : rt;
  assign wd  = memtoreg ? mdr : aluout;
  assign rd1 = (rs == '0) ? '0 : rf[rs];
  assign rd2 = (rt == '0) ? '0 : rf[rt];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (regwrite && wa != '0) begin
      rf[wa] <= wd;
    end
  end

  // ALU
  assign srca = alusrca ? a : pc;

  always_comb begin
    srcb = b;
    case (alusrcb)
      2'b00:   srcb = b;
      2'b01:   srcb = WIDTH'(BEATS);
      2'b10:   srcb = immx;
      default: srcb = immx << SH;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alucont)
      3'b010:  alu_res = srca + srcb;
      3'b110:  alu_res = srca - srcb;
      3'b000:  alu_res = srca & srcb;
      3'b001:  alu_res = srca | srcb;
      3'b111:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  // PC: the sequencer owns the address bus during a fetch, so PC is frozen then
  always_comb begin
    pc_n = pc;
    case (pcsource)
      2'b00:   pc_n = alu_res;
      2'b01:   pc_n = aluout;
      2'b10:   pc_n = jtarget;
      default: pc_n = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    pc <= '0;
    else if (pcen && !fetch_busy) pc <= pc_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      mdr    <= memdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= alu_res;
    end
  end

  assign addr  = fetch_busy ? (pc + WIDTH'(beat)) : (iord ? aluout : pc);
  assign wdata = b;

endmodule

// File: tb/tb_mips_datapath_param.sv
// Bench for mips_datapath_param: WIDTH=8 instance tracked every cycle by an arithmetic
// reference model; a WIDTH=32 instance exercised with directed single-beat fetch/jump steps.
module tb_mips_datapath_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetch_start, mem_valid, pcen, iord, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]  alusrcb, pcsource;
  logic [2:0]  alucont;
  logic [7:0]  memdata;
  logic [31:0] memdata32;

  logic [5:0]  op8, funct8, op32, funct32;
  logic        zero8, busy8, done8, zero32, busy32, done32;
  logic [7:0]  addr8, wdata8;
  logic [31:0] addr32, wdata32;

  mips_datapath_param #(.WIDTH(8), .REGBITS(3)) dut8 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .mem_valid(mem_valid),
    .memdata(memdata), .pcen(pcen), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
    .pcsource(pcsource), .op(op8), .funct(funct8), .zero(zero8), .addr(addr8),
    .wdata(wdata8), .fetch_busy(busy8), .fetch_done(done8)
  );

  mips_datapath_param #(.WIDTH(32), .REGBITS(3)) dut32 (
    .clk(clk), .reset(reset), .fetch_start(fetch_start), .mem_valid(mem_valid),
    .memdata(memdata32), .pcen(pcen), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
    .pcsource(pcsource), .op(op32), .funct(funct32), .zero(zero32), .addr(addr32),
    .wdata(wdata32), .fetch_busy(busy32), .fetch_done(done32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the 8-bit instance (4 beats per instruction, immediates scaled by 4)
  int          m_pc, m_mdr, m_a, m_b, m_aluout, m_beat;
  int          m_rf [8];
  logic [31:0] m_ir;
  bit          m_busy, m_done;

  task automatic m_clear();
    m_pc = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_beat = 0;
    m_ir = 0; m_busy = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
  endtask

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int m_alu_res();
    int sa, sb, imm;
    imm = int'(m_ir[7:0]);
    sa  = alusrca ? m_a : m_pc;
    case (alusrcb)
      2'd0:    sb = m_b;
      2'd1:    sb = 4;
      2'd2:    sb = imm;
      default: sb = (imm * 4) % 256;
    endcase
    case (alucont)
      3'b010:  return (sa + sb) % 256;
      3'b110:  return (sa - sb + 256) % 256;
      3'b000:  return sa & sb;
      3'b001:  return sa | sb;
      3'b111:  return (sx8(sa) < sx8(sb)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Compare the 8-bit instance against the model, then advance both across one edge
  task automatic cyc();
    int res, rs, rt, rd, wa, npc, na, nb;
    #1;
    res = m_alu_res();
    chk("addr",  {24'b0, addr8},  m_busy ? (m_pc + m_beat) % 256 : (iord ? m_aluout : m_pc));
    chk("zero",  {31'b0, zero8},  (res == 0) ? 1 : 0);
    chk("busy",  {31'b0, busy8},  m_busy);
    chk("done",  {31'b0, done8},  m_done);
    chk("op",    {26'b0, op8},    m_ir[31:26]);
    chk("funct", {26'b0, funct8}, m_ir[5:0]);
    chk("wdata", {24'b0, wdata8}, m_b);
    @(posedge clk);
    if (reset) begin
      m_clear();
    end else begin
      rs = int'(m_ir[23:21]); rt = int'(m_ir[18:16]); rd = int'(m_ir[13:11]);
      npc = m_pc;
      if (pcen && !m_busy) begin
        case (pcsource)
          2'd0:    npc = res;
          2'd1:    npc = m_aluout;
          2'd2:    npc = (int'(m_ir[25:0]) * 4) % 256;
          default: npc = m_pc;
        endcase
      end
      na = m_rf[rs]; nb = m_rf[rt];
      wa = regdst ? rd : rt;
      if (regwrite && wa != 0) m_rf[wa] = memtoreg ? m_mdr : m_aluout;
      m_done = 0;
      if (m_busy) begin
        if (mem_valid) begin
          m_ir[m_beat*8 +: 8] = memdata;
          if (m_beat == 3) begin m_busy = 0; m_done = 1; m_beat = 0; end
          else m_beat++;
        end
      end else if (fetch_start) begin
        m_busy = 1; m_beat = 0;
      end
      m_pc = npc; m_a = na; m_b = nb; m_mdr = int'(memdata); m_aluout = res;
    end
    @(negedge clk);
  endtask

  task automatic idle_ctl();
    fetch_start = 0; mem_valid = 0; pcen = 0; iord = 0; regdst = 0; memtoreg = 0;
    regwrite = 0; alusrca = 0; alusrcb = 2'b00; alucont = 3'b010; pcsource = 2'b11;
    memdata = 8'h00; memdata32 = 32'h0;
  endtask

  task automatic reset_now();
    reset = 1; m_clear();
  endtask

  // Fetch one instruction into the 8-bit instance; optional two-cycle stall after beat stall_at
  task automatic fetch8(input logic [31:0] instr, input int stall_at, output int busy_cycles);
    busy_cycles = 0;
    fetch_start = 1; cyc(); fetch_start = 0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1; memdata = instr[8*i +: 8];
      if (busy8) busy_cycles++;
      cyc();
      if (i == stall_at) begin
        mem_valid = 0; memdata = 8'h00;
        repeat (2) begin
          if (busy8) busy_cycles++;
          #1; chk("stall_addr", {24'b0, addr8}, (m_pc + i + 1) % 256);
          cyc();
        end
      end
    end
    mem_valid = 0; memdata = 8'h00;
    #1; chk("done_pulse", {31'b0, done8}, 1);
    cyc();
    #1; chk("done_one_cycle", {31'b0, done8}, 0);
  endtask

  // Load a register of the 8-bit instance through MDR (sel 0: rt, 1: rd)
  task automatic loadreg(input logic sel, input logic [7:0] val);
    memdata = val; cyc();
    memdata = 8'h00; regwrite = 1; memtoreg = 1; regdst = sel; cyc();
    regwrite = 0; memtoreg = 0; regdst = 0;
  endtask

  initial begin
    int bc;
    idle_ctl();
    reset_now();
    cyc();
    #1;
    chk("rst_addr8",  {24'b0, addr8}, 0);
    chk("rst_busy8",  {31'b0, busy8}, 0);
    chk("rst_addr32", addr32, 0);
    chk("rst_wdata32", wdata32, 0);
    reset = 0;

    // Plain fetch from PC=0
    fetch8(32'h00221020, -1, bc);
    chk("fetch_busy_cycles", bc, 4);
    chk("fetch_funct", {26'b0, funct8}, 32'h20);
    chk("fetch_op",    {26'b0, op8},    32'h00);

    // Stall for two cycles after beat 1
    fetch8(32'h00220820, 1, bc);
    chk("stall_busy_cycles", bc, 6);
    chk("stall_funct", {26'b0, funct8}, 32'h20);

    // r1=r2=5 then sub A-B -> zero
    loadreg(1'b1, 8'h05);
    loadreg(1'b0, 8'h05);
    cyc();
    alusrca = 1; alusrcb = 2'b00; alucont = 3'b110;
    #1; chk("sub_zero", {31'b0, zero8}, 1);
    chk("sub_wdata", {24'b0, wdata8}, 5);
    cyc();

    // r1=0x80, r2=0x01 -> signed slt gives 1
    alusrca = 0; alucont = 3'b010;
    loadreg(1'b1, 8'h80);
    loadreg(1'b0, 8'h01);
    cyc();
    alusrca = 1; alusrcb = 2'b00; alucont = 3'b111;
    #1; chk("slt_zero", {31'b0, zero8}, 0);
    cyc();
    alucont = 3'b010; alusrca = 0; iord = 1;
    #1; chk("slt_result", {24'b0, addr8}, 1);
    cyc();
    iord = 0;

    // Writes to entry 0 are discarded
    fetch8(32'h00000020, -1, bc);
    loadreg(1'b0, 8'h7F);
    cyc();
    alusrca = 1; alusrcb = 2'b00; alucont = 3'b001;
    #1; chk("r0_b", {24'b0, wdata8}, 0);
    chk("r0_a_or_b_zero", {31'b0, zero8}, 1);
    cyc();
    idle_ctl();

    // Reset in the middle of a fetch, after beat 2
    fetch_start = 1; cyc(); fetch_start = 0;
    mem_valid = 1;
    for (int i = 0; i < 3; i++) begin memdata = 8'h3C + 8'(i); cyc(); end
    mem_valid = 0;
    #1; chk("pre_rst_busy", {31'b0, busy8}, 1);
    reset_now();
    #1;
    chk("midrst_busy",  {31'b0, busy8},  0);
    chk("midrst_addr",  {24'b0, addr8},  0);
    chk("midrst_funct", {26'b0, funct8}, 0);
    cyc();
    reset = 0;
    fetch8(32'h8C4A1234, -1, bc);
    chk("refetch_cycles", bc, 4);
    chk("refetch_op", {26'b0, op8}, 32'h23);

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      fetch_start = 1'($urandom_range(0, 3) == 0);
      mem_valid   = 1'($urandom);
      memdata     = 8'($urandom);
      memdata32   = $urandom;
      pcen        = 1'($urandom_range(0, 3) == 0);
      iord        = 1'($urandom);
      regdst      = 1'($urandom);
      memtoreg    = 1'($urandom);
      regwrite    = 1'($urandom);
      alusrca     = 1'($urandom);
      alusrcb     = 2'($urandom);
      alucont     = 3'($urandom);
      pcsource    = 2'($urandom);
      if ($urandom_range(0, 99) == 0) reset_now();
      cyc();
      reset = 0;
    end

    // WIDTH=32: single-beat fetch, jump, then PC+1
    idle_ctl();
    reset_now();
    cyc();
    reset = 0;
    fetch_start = 1; cyc(); fetch_start = 0;
    mem_valid = 1; memdata32 = 32'h08000003;
    #1; chk("w32_busy", {31'b0, busy32}, 1);
    chk("w32_fetch_addr", addr32, 0);
    cyc();
    mem_valid = 0; memdata32 = 32'h0;
    #1; chk("w32_done", {31'b0, done32}, 1);
    chk("w32_busy_after", {31'b0, busy32}, 0);
    chk("w32_op", {26'b0, op32}, 32'h02);
    chk("w32_funct", {26'b0, funct32}, 32'h03);
    pcsource = 2'b10; pcen = 1;
    cyc();
    pcen = 0;
    #1; chk("w32_jump_pc", addr32, 32'h00000003);
    alusrca = 0; alusrcb = 2'b01; alucont = 3'b010; pcsource = 2'b00; pcen = 1;
    #1; chk("w32_inc_zero", {31'b0, zero32}, 0);
    cyc();
    pcen = 0;
    #1; chk("w32_inc_pc", addr32, 32'h00000004);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
